// File: rtl/mem_req_pkg.sv
// rtl/mem_req_pkg.sv - shared types, defaults and request-check helpers for mem_req_ctrl
package mem_req_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_f3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // funct3[1:0] is the access size (byte/half/word) for both loads and stores
  function automatic logic req_bad(input logic write, input logic [2:0] funct3,
                                   input logic [1:0] offset);
    logic illegal;
    logic misaligned;
    if (write)
      illegal = (funct3 > F3_SW);
    else
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                 ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    return illegal || misaligned;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b00:   return 4'b0001 << offset;
      2'b01:   return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// rtl/mem_req_ctrl_if.sv - datapath request/response and memory strobe bundle
interface mem_req_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/mem_load_extend.sv
// rtl/mem_load_extend.sv - aligns a memory word to the load offset and sign/zero-extends it
module mem_load_extend
  import mem_req_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = '0;
    case (load_f3_e'(funct3))
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   data = shifted;
      F3_LBU:  data = {24'd0, shifted[7:0]};
      F3_LHU:  data = {16'd0, shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - RV32I load/store to strobe-memory controller; MEM_TIMEOUT_EN enables access abort
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_req_ctrl_if.master bus
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] READ  = ST_READ;
  localparam logic [1:0] WRITE = ST_WRITE;
  localparam logic [1:0] RESP  = ST_RESP;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  state;
  logic        lat_write;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_offset;
  logic [31:0] ext_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`endif

  mem_load_extend u_load_extend (
    .rdata  (bus.mem_rdata),
    .offset (lat_offset),
    .funct3 (lat_funct3),
    .data   (ext_data)
  );

  assign bus.req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      lat_write           <= 1'b0;
      lat_funct3          <= 3'd0;
      lat_offset          <= 2'd0;
      bus.mem_read        <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_address     <= '0;
      bus.mem_wdata       <= '0;
      bus.mem_byte_enable <= '0;
      bus.rsp_valid       <= 1'b0;
      bus.rsp_rdata       <= '0;
      bus.rsp_err         <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt                 <= '0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write  <= bus.req_write;
            lat_funct3 <= bus.req_funct3;
            lat_offset <= bus.req_addr[1:0];
            if (req_bad(bus.req_write, bus.req_funct3, bus.req_addr[1:0])) begin
              // rejected requests never touch memory
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              bus.mem_address     <= {bus.req_addr[31:2], 2'b00};
              bus.mem_byte_enable <= byte_enable(bus.req_funct3[1:0], bus.req_addr[1:0]);
              bus.mem_wdata       <= bus.req_wdata << {bus.req_addr[1:0], 3'b000};
              bus.mem_read        <= !bus.req_write;
              bus.mem_write       <= bus.req_write;
              state               <= bus.req_write ? WRITE : READ;
`ifdef MEM_TIMEOUT_EN
              cnt                 <= '0;
`endif
            end
          end
        end
        READ, WRITE: begin
          if (bus.mem_resp) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= lat_write ? 32'd0 : ext_data;
            state         <= RESP;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
            state         <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - randomized self-checking bench for mem_req_ctrl with a transaction-level model
module tb_mem_req_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_req_ctrl_if bus();

  mem_req_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference rules ----------------
  function automatic bit is_bad(input bit w, input bit [2:0] f3, input bit [31:0] a);
    bit legal;
    int sz;
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = int'(f3) % 4;
    if (!legal) return 1'b1;
    if (sz == 1 && (a % 2) != 0) return 1'b1;
    if (sz == 2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [3:0] exp_be(input bit [2:0] f3, input bit [31:0] a);
    int sz;
    int off;
    sz = int'(f3) % 4;
    off = int'(a % 4);
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic bit [31:0] exp_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
    bit [31:0] sh;
    longint v;
    sh = d >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = longint'(sh & 32'hFF);   if (v > 127)   v -= 256;   end
      3'd1: begin v = longint'(sh & 32'hFFFF); if (v > 32767) v -= 65536; end
      3'd2: v = longint'(sh);
      3'd4: v = longint'(sh & 32'hFF);
      3'd5: v = longint'(sh & 32'hFFFF);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // ---------------- memory responder ----------------
  int        mem_mode = 0;   // 0 random, 1 fixed delay/data, 2 never answers
  int        fix_delay = 0;
  bit [31:0] fix_data = 0;
  bit        force_resp = 0;

  initial begin
    int cnt;
    int target;
    cnt = 0;
    target = 0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = $urandom;
      if (force_resp) begin
        bus.mem_resp = 1'b1;
        force_resp = 1'b0;
      end else if (bus.mem_read || bus.mem_write) begin
        if (mem_mode != 2) begin
          if (cnt >= target) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = (mem_mode == 1) ? fix_data : $urandom;
            cnt = 0;
          end else cnt++;
        end
      end else begin
        cnt = 0;
        target = (mem_mode == 1) ? fix_delay : int'($urandom_range(0, 3));
        if (mem_mode == 0 && $urandom_range(0, 5) == 0) bus.mem_resp = 1'b1;
      end
    end
  end

  // ---------------- transaction model and per-cycle compare ----------------
  typedef struct {
    bit        write;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
  } txn_t;

  bit        model_on = 0;
  bit        busy = 0;
  bit        waiting = 0;
  bit        rsp_due = 0;
  bit        exp_err = 0;
  bit [31:0] exp_rdata = 0;
  int        wait_cnt = 0;
  txn_t      cur;

  always @(negedge clk) begin
    if (model_on) begin
      check("req_ready", 32'(bus.req_ready), 32'(!busy));
      check("mem_read", 32'(bus.mem_read), 32'(waiting && !cur.write));
      check("mem_write", 32'(bus.mem_write), 32'(waiting && cur.write));
      if (waiting) begin
        check("mem_address", bus.mem_address, cur.addr & 32'hFFFF_FFFC);
        check("mem_byte_enable", 32'(bus.mem_byte_enable), 32'(exp_be(cur.f3, cur.addr)));
        if (cur.write) check("mem_wdata", bus.mem_wdata, 32'(cur.wdata << (8 * (cur.addr % 4))));
      end
      check("rsp_valid", 32'(bus.rsp_valid), 32'(rsp_due));
      if (rsp_due) begin
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
      end
    end
    if (!rst_n) begin
      busy = 0; waiting = 0; rsp_due = 0; model_on = 1;
    end else if (model_on) begin
      if (rsp_due) begin
        rsp_due = 0;
        busy = 0;
      end else if (waiting) begin
        if (bus.mem_resp) begin
          waiting = 0; rsp_due = 1; exp_err = 0;
          exp_rdata = cur.write ? 32'd0 : exp_load(cur.f3, cur.addr, bus.mem_rdata);
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          wait_cnt++;
          if (wait_cnt == TO) begin
            waiting = 0; rsp_due = 1; exp_err = 1; exp_rdata = 0;
          end
        end
`endif
      end else if (!busy && bus.req_valid) begin
        busy = 1;
        cur.write = bus.req_write;
        cur.f3    = bus.req_funct3;
        cur.addr  = bus.req_addr;
        cur.wdata = bus.req_wdata;
        wait_cnt  = 0;
        if (is_bad(cur.write, cur.f3, cur.addr)) begin
          rsp_due = 1; exp_err = 1; exp_rdata = 0;
        end else waiting = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1;
    end
    check("req_accepted", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_strobe();
    bit seen;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) seen = 1;
    end
    check("strobe_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_rsp(output bit [31:0] rd, output bit er);
    bit seen;
    seen = 0; rd = 0; er = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin seen = 1; rd = bus.rsp_rdata; er = bus.rsp_err; end
    end
    check("rsp_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] rd;
    bit        er;
    int        n;
    bus.req_valid = 0; bus.req_write = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("reset_mem_address", bus.mem_address, 32'd0);
    check("reset_mem_wdata", bus.mem_wdata, 32'd0);
    check("reset_byte_enable", 32'(bus.mem_byte_enable), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);

    // LW 0x100, memory answers on the third strobe cycle
    mem_mode = 1; fix_delay = 2; fix_data = 32'hDEADBEEF;
    send(0, 3'b010, 32'h100, 0);
    wait_strobe();
    check("lw_address", bus.mem_address, 32'h100);
    check("lw_be", 32'(bus.mem_byte_enable), 32'hF);
    wait_rsp(rd, er);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);

    fix_delay = 0; fix_data = 32'h80FF0000;
    send(0, 3'b000, 32'h103, 0);
    wait_rsp(rd, er);
    check("lb_rdata", rd, 32'hFFFFFF80);
    send(0, 3'b100, 32'h103, 0);
    wait_rsp(rd, er);
    check("lbu_rdata", rd, 32'h00000080);

    fix_delay = 3;
    send(1, 3'b001, 32'h202, 32'h0000ABCD);
    wait_strobe();
    check("sh_address", bus.mem_address, 32'h200);
    check("sh_be", 32'(bus.mem_byte_enable), 32'hC);
    check("sh_wdata", bus.mem_wdata, 32'hABCD0000);
    wait_rsp(rd, er);
    check("sh_rdata", rd, 32'd0);

    // misaligned word: rejected without a strobe, answered the next cycle
    send(0, 3'b010, 32'h101, 0);
    @(negedge clk);
    check("mis_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("mis_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("mis_no_strobe", 32'(bus.mem_read | bus.mem_write), 32'd0);

    // reset while READ is waiting, then a late mem_resp that must be ignored
    mem_mode = 2;
    send(0, 3'b010, 32'h300, 0);
    wait_strobe();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    force_resp = 1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) n++;
    end
    check("rst_no_rsp", 32'(n), 32'd0);
    mem_mode = 1; fix_delay = 1; fix_data = 32'h12345678;
    send(0, 3'b010, 32'h304, 0);
    wait_rsp(rd, er);
    check("post_rst_rdata", rd, 32'h12345678);
    check("post_rst_err", 32'(er), 32'd0);

`ifdef MEM_TIMEOUT_EN
    mem_mode = 2;
    send(0, 3'b010, 32'h40, 0);
    wait_strobe();
    n = 1; rd = 32'hFFFF_FFFF; er = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.mem_read) n++;
      else begin
        er = bus.rsp_valid && bus.rsp_err;
        rd = bus.rsp_rdata;
        break;
      end
    end
    check("timeout_strobe_cycles", 32'(n), 32'd8);
    check("timeout_err", 32'(er), 32'd1);
    check("timeout_rdata", rd, 32'd0);
`endif

    mem_mode = 0;
    repeat (300) begin
      bit        w;
      bit [2:0]  f3;
      bit [31:0] a;
      int        pick;
      w = 1'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 9));
      if (pick < 2) f3 = 3'($urandom_range(0, 7));
      else if (w) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      send(w, f3, a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the cycles in READ/WRITE before abort (used only under MEM_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  a datapath load/store request is present.
REQ-005 SHALL have port req_ready  out  1  the controller accepts a request this cycle.
REQ-006 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  in  3  RV32I width code: LB/LH/LW/LBU/LHU; SB/SH/SW.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  out  1  the request was misaligned, illegal or timed out; valid with rsp_valid.
REQ-013 SHALL have ports mem_read and mem_write  out  1  each; memory strobes.
REQ-014 SHALL have port mem_address  out  32  word-aligned address.
REQ-015 SHALL have ports mem_wdata  out  32  and mem_byte_enable  out  4.
REQ-016 SHALL have ports mem_rdata  in  32  and mem_resp  in  1  (mem_resp is a one-cycle pulse).

Function
REQ-017 SHALL implement the FSM IDLE, READ, WRITE, RESP; req_ready = (state==IDLE).
REQ-018 SHALL, in IDLE on req_valid, latch the request and enter RESP with err=1 when it is misaligned (half with addr[0]=1; word with addr[1:0]!=0) or illegal (load funct3 011/110/111; store funct3 >010); otherwise it SHALL enter READ or WRITE.
REQ-019 SHALL derive mem_byte_enable as SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111, and mem_wdata = req_wdata << 8*addr[1:0].
REQ-020 SHALL drive mem_address = {addr[31:2],2'b00}.
REQ-021 SHALL assert mem_read only in READ and mem_write only in WRITE; they are never both high.
REQ-022 SHALL hold mem_address, mem_wdata and mem_byte_enable constant from the entry to READ/WRITE until mem_resp is sampled.
REQ-023 SHALL, in READ on mem_resp, capture mem_rdata >> 8*addr[1:0], sign-extend it for LB/LH or zero-extend it for LBU/LHU, and enter RESP.
REQ-024 SHALL, in WRITE on mem_resp, enter RESP.
REQ-025 SHALL, in RESP, assert rsp_valid for exactly one cycle and return to IDLE.
REQ-026 SHALL hold the strobes low in IDLE and RESP, which guarantees at least 2 deasserted cycles between accesses so the memory sees a fresh rising strobe.
REQ-027 SHALL ignore mem_resp in IDLE and RESP.
REQ-028 SHALL meet the latency: rsp_valid occurs 1 cycle after the sampled mem_resp; for an err request, the cycle after acceptance.

Reset
REQ-029 SHALL, on a rising edge with rst_n=0, set state=IDLE and drive mem_read=mem_write=0, mem_address=mem_wdata=0, mem_byte_enable=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
REQ-030 SHALL ignore req_valid while rst_n=0.
REQ-031 SHALL, on reset mid-READ/WRITE, drop the strobe at that edge, emit no rsp_valid for the aborted request, and ignore a late mem_resp.

Configuration
REQ-032 SHALL, with MEM_TIMEOUT_EN defined, count cycles in READ/WRITE; at TIMEOUT_CYCLES without mem_resp it SHALL drop the strobe and enter RESP with rsp_err=1 and rsp_rdata=0.
REQ-033 SHALL, without MEM_TIMEOUT_EN, have no counter and wait indefinitely for mem_resp.

Structure
REQ-034 SHALL place the funct3 load/store enums, the FSM state enum and the TIMEOUT_CYCLES default in package mem_req_pkg.
REQ-035 SHALL place the load shift/extend logic in sub-module mem_load_extend (inputs rdata, offset, funct3; output data).

Verification
REQ-036 SHALL cover: LW 0x100, memory returns 0xDEADBEEF after 2 cycles -> mem_read held with address 0x100 and be 1111, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 SHALL cover: LB 0x103 with mem_rdata 0x80FF0000 -> rsp_rdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-038 SHALL cover: SH 0x202 with wdata 0x0000ABCD -> address 0x200, be 1100, mem_wdata 0xABCD0000, all stable until mem_resp.
REQ-039 SHALL cover: LW 0x101 -> no strobe, and rsp_valid with rsp_err=1 the next cycle.
REQ-040 SHALL cover: rst_n low in READ -> mem_read=0 after the edge, no rsp_valid; a following LW completes normally.
REQ-041 SHALL cover: MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mem_resp never asserted -> strobe dropped after 8 cycles, rsp_err=1.
